// File: rtl/hangman_controller.sv
// Hangman game sequencer: latches a four-letter word, checks one guess per two
// cycles, and tracks revealed positions, guessed letters and remaining lives.
module hangman_controller #(
  parameter int         MAX_LIVES = 6,
  parameter logic [5:0] BLANK     = 6'h3F
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] letter1,
  input  logic [5:0] letter2,
  input  logic [5:0] letter3,
  input  logic [5:0] letter4,
  input  logic       guess_valid,
  input  logic [5:0] guess_letter,
  output logic       guess_ready,
  output logic [5:0] disp1,
  output logic [5:0] disp2,
  output logic [5:0] disp3,
  output logic [5:0] disp4,
  output logic [3:0] revealed,
  output logic [2:0] lives_left,
  output logic       playing,
  output logic       won,
  output logic       lost,
  output logic       hit,
  output logic       miss,
  output logic       repeat_guess,
  output logic       reject
);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, CHECK, WIN, LOSE} state_t;

  state_t      state, state_next;
  logic [5:0]  word1, word2, word3, word4;
  logic [5:0]  guess_p0;
  logic [25:0] guessed;

  logic        in_range;
  logic [4:0]  idx;
  logic [25:0] guess_bit;
  logic        seen;
  logic [3:0]  match;
  logic [3:0]  reveal_next;
  logic [2:0]  lives_next;

  function automatic logic [2:0] sat_dec(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  // Guess evaluation, decoded from the captured guess and registered game state
  always_comb begin
    in_range    = (guess_p0 >= 6'h0A) && (guess_p0 <= 6'h23);
    idx         = 5'(guess_p0 - 6'h0A);
    guess_bit   = 26'd1 << idx;
    seen        = in_range && |(guessed & guess_bit);
    match       = {word4 == guess_p0, word3 == guess_p0,
                   word2 == guess_p0, word1 == guess_p0};
    reveal_next = revealed | match;
    lives_next  = sat_dec(lives_left);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:  state_next = WAIT;
      WAIT:  if (guess_valid) state_next = CHECK;
      CHECK: begin
        state_next = WAIT;
        if (in_range && !seen) begin
          if (|match) begin
            if (reveal_next == 4'b1111) state_next = WIN;
          end else if (lives_next == 3'd0) begin
            state_next = LOSE;
          end
        end
      end
      default: state_next = state;
    endcase
    // A new game request preempts everything, including a guess under evaluation
    if (start && state != LOAD) state_next = LOAD;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      word1        <= '0;
      word2        <= '0;
      word3        <= '0;
      word4        <= '0;
      guess_p0     <= '0;
      guessed      <= '0;
      revealed     <= '0;
      lives_left   <= '0;
      hit          <= 1'b0;
      miss         <= 1'b0;
      repeat_guess <= 1'b0;
      reject       <= 1'b0;
    end else begin
      hit          <= 1'b0;
      miss         <= 1'b0;
      repeat_guess <= 1'b0;
      reject       <= 1'b0;
      case (state)
        LOAD: begin
          word1      <= letter1;
          word2      <= letter2;
          word3      <= letter3;
          word4      <= letter4;
          guessed    <= '0;
          revealed   <= '0;
          lives_left <= 3'(MAX_LIVES);
        end
        WAIT: if (guess_valid) guess_p0 <= guess_letter;
        CHECK: if (!start) begin
          if (!in_range) begin
            reject <= 1'b1;
          end else if (seen) begin
            repeat_guess <= 1'b1;
          end else begin
            guessed <= guessed | guess_bit;
            if (|match) begin
              revealed <= reveal_next;
              hit      <= 1'b1;
            end else begin
              lives_left <= lives_next;
              miss       <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign guess_ready = (state == WAIT);
  assign playing     = (state == WAIT) || (state == CHECK);
  assign won         = (state == WIN);
  assign lost        = (state == LOSE);
  assign disp1       = (revealed[0] || lost) ? word1 : BLANK;
  assign disp2       = (revealed[1] || lost) ? word2 : BLANK;
  assign disp3       = (revealed[2] || lost) ? word3 : BLANK;
  assign disp4       = (revealed[3] || lost) ? word4 : BLANK;

endmodule
